// File: rtl/gshare_pkg.sv
// Shared constants and helpers for the gshare branch predictor.
// The index fold mixes PC bits with the global history.
package gshare_pkg;

    localparam int DEF_INDEX_LEN = 7;
    localparam int DEF_TAG_LEN   = 7;
    localparam int DEF_HIST_LEN  = 8;
    localparam int DEF_CTR_BITS  = 2;
    localparam int PC_W          = 16;

    function automatic int weak_taken(input int ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

    function automatic int weak_not_taken(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    localparam int WEAK_TAKEN     = weak_taken(DEF_CTR_BITS);
    localparam int WEAK_NOT_TAKEN = weak_not_taken(DEF_CTR_BITS);

    // The history arrives zero-extended to PC_W bits. The mask keeps the low
    // index_len bits, which truncates any longer history.
    function automatic logic [PC_W-1:0] fold_index(input logic [PC_W-1:0] pc,
                                                   input logic [PC_W-1:0] hist,
                                                   input int              index_len);
        logic [PC_W-1:0] mix;
        logic [PC_W-1:0] mask;
        mix  = (pc >> 2) ^ hist;
        mask = PC_W'((32'd1 << index_len) - 32'd1);
        return mix & mask;
    endfunction

endpackage

// File: rtl/gshare_table.sv
// Predictor storage with per-entry valid, tag and counter.
// It has one asynchronous lookup port and one synchronous write port.
// The write port also exposes its addressed entry so the caller can do read-modify-write.
module gshare_table #(
    parameter int INDEX_LEN = 7,
    parameter int TAG_LEN   = 7,
    parameter int CTR_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INDEX_LEN-1:0] rd_idx,
    output logic                 rd_valid,
    output logic [TAG_LEN-1:0]   rd_tag,
    output logic [CTR_BITS-1:0]  rd_ctr,
    input  logic [INDEX_LEN-1:0] wr_idx,
    output logic                 cur_valid,
    output logic [TAG_LEN-1:0]   cur_tag,
    output logic [CTR_BITS-1:0]  cur_ctr,
    input  logic                 wr_en,
    input  logic [TAG_LEN-1:0]   wr_tag,
    input  logic [CTR_BITS-1:0]  wr_ctr
);

    localparam int DEPTH = 1 << INDEX_LEN;

    logic [DEPTH-1:0]    valid_q;
    logic [TAG_LEN-1:0]  tag_mem [DEPTH];
    logic [CTR_BITS-1:0] ctr_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tags and counters carry no reset. A write during reset lands in an entry
    // that is still invalid, so it is never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            ctr_mem[wr_idx] <= wr_ctr;
        end
    end

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_mem[rd_idx];
    assign rd_ctr    = ctr_mem[rd_idx];
    assign cur_valid = valid_q[wr_idx];
    assign cur_tag   = tag_mem[wr_idx];
    assign cur_ctr   = ctr_mem[wr_idx];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: tagged table lookup, counter training,
// and a speculative global history with mispredict recovery.
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int INDEX_LEN = DEF_INDEX_LEN,
    parameter int TAG_LEN   = DEF_TAG_LEN,
    parameter int HIST_LEN  = DEF_HIST_LEN,
    parameter int CTR_BITS  = DEF_CTR_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                predict_valid,
    input  logic [15:0]         pc_bits_read,
    input  logic                update_valid,
    input  logic [15:0]         pc_bits_write,
    input  logic                outcome,
    input  logic [HIST_LEN-1:0] update_history,
    input  logic                mispredict,
    output logic                prediction,
    output logic                hit,
    output logic [HIST_LEN-1:0] history_snapshot
);

    if (INDEX_LEN < 1 || TAG_LEN < 1 || INDEX_LEN + TAG_LEN > 14) begin : g_bad_geometry
        $error("gshare_predictor: INDEX_LEN+TAG_LEN must be <= 14 and each >= 1");
    end
    if (HIST_LEN < 1 || HIST_LEN > 16) begin : g_bad_hist
        $error("gshare_predictor: HIST_LEN must be 1..16");
    end
    if (CTR_BITS < 2 || CTR_BITS > 4) begin : g_bad_ctr
        $error("gshare_predictor: CTR_BITS must be 2..4");
    end

    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(weak_taken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(weak_not_taken(CTR_BITS));

    function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c,
                                                    input logic                up);
        if (up) begin
            return (&c) ? c : c + CTR_BITS'(1);
        end
        return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    logic [HIST_LEN-1:0]  ghr;
    logic [INDEX_LEN-1:0] rd_idx;
    logic [INDEX_LEN-1:0] wr_idx;
    logic [TAG_LEN-1:0]   rd_tag_pc;
    logic [TAG_LEN-1:0]   wr_tag_pc;
    logic                 rd_valid;
    logic [TAG_LEN-1:0]   rd_tag_q;
    logic [CTR_BITS-1:0]  rd_ctr;
    logic                 cur_valid;
    logic [TAG_LEN-1:0]   cur_tag;
    logic [CTR_BITS-1:0]  cur_ctr;
    logic [CTR_BITS-1:0]  wr_ctr;

    assign rd_idx    = INDEX_LEN'(fold_index(pc_bits_read,  PC_W'(ghr),            INDEX_LEN));
    assign wr_idx    = INDEX_LEN'(fold_index(pc_bits_write, PC_W'(update_history), INDEX_LEN));
    assign rd_tag_pc = pc_bits_read[INDEX_LEN+TAG_LEN+1 -: TAG_LEN];
    assign wr_tag_pc = pc_bits_write[INDEX_LEN+TAG_LEN+1 -: TAG_LEN];

    gshare_table #(
        .INDEX_LEN (INDEX_LEN),
        .TAG_LEN   (TAG_LEN),
        .CTR_BITS  (CTR_BITS)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag_q),
        .rd_ctr    (rd_ctr),
        .wr_idx    (wr_idx),
        .cur_valid (cur_valid),
        .cur_tag   (cur_tag),
        .cur_ctr   (cur_ctr),
        .wr_en     (update_valid),
        .wr_tag    (wr_tag_pc),
        .wr_ctr    (wr_ctr)
    );

    // Lookups see the table contents before this cycle's write. Reset clears
    // the valid bits asynchronously, so hit falls immediately.
    assign hit        = rd_valid && (rd_tag_q == rd_tag_pc);
    assign prediction = hit && rd_ctr[CTR_BITS-1];

    always_comb begin
        wr_ctr = outcome ? CTR_WT : CTR_WNT;
        if (cur_valid && (cur_tag == wr_tag_pc)) begin
            wr_ctr = sat_step(cur_ctr, outcome);
        end
    end

    // Recovery takes priority over the speculative shift. The casts keep only
    // the newest HIST_LEN bits, so a 1-bit history holds just the newest bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr <= '0;
        end else if (update_valid && mispredict) begin
            ghr <= HIST_LEN'({update_history, outcome});
        end else if (predict_valid) begin
            ghr <= HIST_LEN'({ghr, prediction});
        end
    end

    assign history_snapshot = ghr;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor at default parameters. Expected outputs
// are queued per step and popped for comparison before the next clock edge.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        predict_valid;
    logic [15:0] pc_bits_read;
    logic        update_valid;
    logic [15:0] pc_bits_write;
    logic        outcome;
    logic [7:0]  update_history;
    logic        mispredict;
    logic        prediction;
    logic        hit;
    logic [7:0]  history_snapshot;

    typedef struct {
        string      tag;
        logic       hit;
        logic       pred;
        logic [7:0] hist;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    gshare_predictor dut (
        .clk              (clk),
        .reset            (reset),
        .predict_valid    (predict_valid),
        .pc_bits_read     (pc_bits_read),
        .update_valid     (update_valid),
        .pc_bits_write    (pc_bits_write),
        .outcome          (outcome),
        .update_history   (update_history),
        .mispredict       (mispredict),
        .prediction       (prediction),
        .hit              (hit),
        .history_snapshot (history_snapshot)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: no expected entry for DUT output");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert ({hit, prediction, history_snapshot} === {e.hit, e.pred, e.hist}) else begin
            errors++;
            $error("FAIL %s: observed hit=%b pred=%b hist=%02h, expected hit=%b pred=%b hist=%02h",
                   e.tag, hit, prediction, history_snapshot, e.hit, e.pred, e.hist);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then compare the combinational
    // outputs before the next rising edge commits any state change.
    task automatic step(input logic r, input logic pv, input logic [15:0] pcr,
                        input logic uv, input logic [15:0] pcw, input logic oc,
                        input logic [7:0] uh, input logic mp, input string tag,
                        input logic eh, input logic ep, input logic [7:0] es);
        exp_t e;
        @(negedge clk);
        reset          = r;
        predict_valid  = pv;
        pc_bits_read   = pcr;
        update_valid   = uv;
        pc_bits_write  = pcw;
        outcome        = oc;
        update_history = uh;
        mispredict     = mp;
        e.tag  = tag;
        e.hit  = eh;
        e.pred = ep;
        e.hist = es;
        sb.push_back(e);
        #2;
        check_out();
    endtask

    initial begin
        reset          = 1'b1;
        predict_valid  = 1'b0;
        pc_bits_read   = '0;
        update_valid   = 1'b0;
        pc_bits_write  = '0;
        outcome        = 1'b0;
        update_history = '0;
        mispredict     = 1'b0;
        repeat (2) @(negedge clk);

        // Reset held: lookup, update and shift are all ignored.
        step(1, 1, 16'h0040, 1, 16'h0040, 1, 8'h00, 1, "during_reset",    0, 0, 8'h00);
        step(0, 0, 16'h0040, 0, 16'h0000, 0, 8'h00, 0, "first_lookup",    0, 0, 8'h00);
        // Same-cycle read of the entry being allocated returns the old contents.
        step(0, 0, 16'h0040, 1, 16'h0040, 1, 8'h00, 0, "no_bypass",       0, 0, 8'h00);
        step(0, 0, 16'h0040, 1, 16'h0040, 1, 8'h00, 0, "alloc_weak_taken",1, 1, 8'h00);
        step(0, 0, 16'h0040, 1, 16'h0040, 1, 8'h00, 0, "ctr_3",           1, 1, 8'h00);
        step(0, 0, 16'h0040, 1, 16'h0040, 1, 8'h00, 0, "ctr_sat_a",       1, 1, 8'h00);
        step(0, 0, 16'h0040, 1, 16'h0040, 0, 8'h00, 0, "ctr_sat_b",       1, 1, 8'h00);
        step(0, 0, 16'h0040, 1, 16'h0040, 0, 8'h00, 0, "ctr_dec_2",       1, 1, 8'h00);
        step(0, 0, 16'h0040, 1, 16'h0040, 1, 8'h00, 0, "ctr_dec_1",       1, 0, 8'h00);
        // Prime index 0x12 and 0x15; non-mispredict updates leave the GHR alone.
        step(0, 0, 16'h0040, 1, 16'h0040, 1, 8'h02, 0, "ctr_back_2",      1, 1, 8'h00);
        step(0, 0, 16'h0040, 1, 16'h0040, 1, 8'h05, 0, "ghr_kept",        1, 1, 8'h00);
        // Speculative shifts with predictions 1,0,1,1.
        step(0, 1, 16'h0040, 0, 16'h0000, 0, 8'h00, 0, "spec_0",          1, 1, 8'h00);
        step(0, 1, 16'h0040, 0, 16'h0000, 0, 8'h00, 0, "spec_1",          0, 0, 8'h01);
        step(0, 1, 16'h0040, 0, 16'h0000, 0, 8'h00, 0, "spec_2",          1, 1, 8'h02);
        step(0, 1, 16'h0040, 0, 16'h0000, 0, 8'h00, 0, "spec_3",          1, 1, 8'h05);
        // Recovery and predict in the same cycle: recovery wins.
        step(0, 1, 16'h0040, 1, 16'h0040, 0, 8'h05, 1, "ghr_0b",          0, 0, 8'h0B);
        step(0, 0, 16'h0040, 0, 16'h0000, 0, 8'h00, 0, "recover_0a",      0, 0, 8'h0A);
        // Alias 0x8040 onto index 0x10 with a new tag; recovery zeroes the GHR.
        step(0, 0, 16'h0040, 1, 16'h8040, 0, 8'h00, 1, "pre_alias",       0, 0, 8'h0A);
        step(0, 0, 16'h0040, 1, 16'h8040, 1, 8'h00, 0, "alias_miss",      0, 0, 8'h00);
        step(0, 1, 16'h8040, 0, 16'h0000, 0, 8'h00, 0, "alias_hit",       1, 1, 8'h00);
        step(0, 0, 16'h8044, 0, 16'h0000, 0, 8'h00, 0, "alias_hit_ghr1",  1, 1, 8'h01);
        // Asynchronous reset mid-sequence with colliding activity.
        step(1, 1, 16'h8044, 1, 16'h8044, 1, 8'h01, 0, "reset_immediate", 0, 0, 8'h00);
        step(0, 0, 16'h8040, 0, 16'h0000, 0, 8'h00, 0, "after_reset",     0, 0, 8'h00);
        step(0, 0, 16'h0040, 1, 16'h0040, 0, 8'h00, 0, "realloc_nt",      0, 0, 8'h00);
        step(0, 0, 16'h0040, 0, 16'h0000, 0, 8'h00, 0, "weak_not_taken",  1, 0, 8'h00);

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
